// File: rtl/nexusv_bus_bridge.sv
// nexusv_bus_bridge: core load/store to NUM_SLV-region APB-style bridge with byte lanes
// and load extension. Optional ACCESS timeout is enabled with `define NEXUSV_BUS_TIMEOUT_EN.
module nexusv_bus_bridge #(
    parameter int unsigned           NUM_SLV     = 4,
    parameter logic [NUM_SLV*32-1:0] REGION_BASE = {32'h8000_6000, 32'h8000_5000,
                                                    32'h8000_4000, 32'h8000_3000},
    parameter logic [NUM_SLV*32-1:0] REGION_MASK = {32'hFFFF_F000, 32'hFFFF_F000,
                                                    32'hFFFF_F000, 32'hFFFF_F000},
    parameter int unsigned           TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [NUM_SLV-1:0]    slv_sel,
    output logic                  slv_enable,
    output logic                  slv_write,
    output logic [31:0]           slv_addr,
    output logic [31:0]           slv_wdata,
    output logic [3:0]            slv_wstrb,
    input  logic [NUM_SLV*32-1:0] slv_rdata,
    input  logic [NUM_SLV-1:0]    slv_ready,
    input  logic [NUM_SLV-1:0]    slv_err
);

    localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [2:0]       f3_q, f3_d;
    logic             write_q, write_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             resp_err_n;
    logic [31:0]      resp_rdata_n;

    logic             hit_any;
    logic [IDX_W-1:0] hit_idx;
    logic             f3_bad, misaligned, dec_err;
    logic [31:0]      lane_wdata;
    logic [3:0]       lane_wstrb;
    logic [31:0]      sel_rdata, shifted, load_ext;
    logic             sel_ready, sel_err;

    logic               req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_err_q, resp_err_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic [NUM_SLV-1:0] slv_sel_q, slv_sel_d;
    logic               slv_enable_q, slv_enable_d;
    logic               slv_write_q, slv_write_d;
    logic [31:0]        slv_addr_q, slv_addr_d;
    logic [31:0]        slv_wdata_q, slv_wdata_d;
    logic [3:0]         slv_wstrb_q, slv_wstrb_d;

`ifdef NEXUSV_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    // Region decode; scanning downwards leaves the lowest matching index.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((req_addr & REGION_MASK[32*i +: 32]) == REGION_BASE[32*i +: 32]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        f3_bad     = 1'b0;
        misaligned = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = req_addr[0];
            3'b010:         misaligned = |req_addr[1:0];
            default:        f3_bad     = 1'b1;
        endcase
        dec_err = f3_bad | misaligned | ~hit_any;
    end

    // Store lane placement; loads drive no strobes and no data.
    always_comb begin
        lane_wdata = req_wdata;
        lane_wstrb = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                lane_wdata = {4{req_wdata[7:0]}};
                lane_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{req_wdata[15:0]}};
                lane_wstrb = 4'b0011 << req_addr[1:0];
            end
            default: ;
        endcase
        if (!req_write) begin
            lane_wdata = '0;
            lane_wstrb = 4'b0000;
        end
    end

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_rdata = slv_rdata[32*i +: 32];
                sel_ready = slv_ready[i];
                sel_err   = slv_err[i];
            end
        end
        shifted = sel_rdata >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_ext = {24'h0, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_ext = {16'h0, shifted[15:0]};
            default: load_ext = sel_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            f3_q    <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            f3_q    <= f3_d;
            write_q <= write_d;
            idx_q   <= idx_d;
        end
    end

    // Next state; resp_*_n carry the completion status on the edge entering RESP.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        f3_d         = f3_q;
        write_d      = write_q;
        idx_d        = idx_q;
        resp_err_n   = 1'b0;
        resp_rdata_n = '0;
`ifdef NEXUSV_BUS_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = lane_wdata;
                    wstrb_d = lane_wstrb;
                    f3_d    = req_funct3;
                    write_d = req_write;
                    idx_d   = hit_idx;
                    if (dec_err) begin
                        state_d    = S_RESP;
                        resp_err_n = 1'b1;
                    end else begin
                        state_d = S_SETUP;
`ifdef NEXUSV_BUS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (sel_ready) begin
                    state_d      = S_RESP;
                    resp_err_n   = sel_err;
                    resp_rdata_n = (sel_err || write_q) ? 32'h0 : load_ext;
                end
`ifdef NEXUSV_BUS_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d    = S_RESP;
                    resp_err_n = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, decoded from the state being entered.
    always_comb begin
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        resp_err_d   = resp_err_n;
        resp_rdata_d = resp_rdata_n;
        slv_sel_d    = '0;
        slv_enable_d = 1'b0;
        slv_write_d  = 1'b0;
        slv_addr_d   = '0;
        slv_wdata_d  = '0;
        slv_wstrb_d  = '0;
        if (state_d == S_SETUP || state_d == S_ACCESS) begin
            slv_sel_d    = NUM_SLV'(1) << idx_d;
            slv_enable_d = (state_d == S_ACCESS);
            slv_write_d  = write_d;
            slv_addr_d   = {addr_d[31:2], 2'b00};
            slv_wdata_d  = wdata_d;
            slv_wstrb_d  = wstrb_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            slv_sel_q    <= '0;
            slv_enable_q <= 1'b0;
            slv_write_q  <= 1'b0;
            slv_addr_q   <= '0;
            slv_wdata_q  <= '0;
            slv_wstrb_q  <= '0;
        end else begin
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            slv_sel_q    <= slv_sel_d;
            slv_enable_q <= slv_enable_d;
            slv_write_q  <= slv_write_d;
            slv_addr_q   <= slv_addr_d;
            slv_wdata_q  <= slv_wdata_d;
            slv_wstrb_q  <= slv_wstrb_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign slv_sel    = slv_sel_q;
    assign slv_enable = slv_enable_q;
    assign slv_write  = slv_write_q;
    assign slv_addr   = slv_addr_q;
    assign slv_wdata  = slv_wdata_q;
    assign slv_wstrb  = slv_wstrb_q;

endmodule
